// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the FSM state encoding and the derived address-field widths.
package dcache_ctrl_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  // Word-offset field width.
  function automatic int unsigned off_w(input int unsigned words_per_block);
    return $clog2(words_per_block);
  endfunction

  // Set-index field width.
  function automatic int unsigned idx_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag field width: whatever address bits remain above index and offset.
  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned words_per_block,
                                        input int unsigned num_sets);
    return addr_w - $clog2(words_per_block) - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus of the data cache, plus its performance counters.
// slave  : the cache (takes CPU requests, issues block requests to memory)
// master : the environment (CPU + block memory)
interface dcache_ctrl_if #(
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned CNT_W           = 16
);
  import dcache_ctrl_pkg::*;

  localparam int unsigned OFF_W = off_w(WORDS_PER_BLOCK);
  localparam int unsigned BLK_W = DATA_W * WORDS_PER_BLOCK;

  logic                    READ;
  logic                    WRITE;
  logic [ADDR_W-1:0]       ADDRESS;
  logic [DATA_W-1:0]       WRITEDATA;
  logic [DATA_W-1:0]       READDATA;
  logic                    BUSYWAIT;
  logic                    MEM_READ;
  logic                    MEM_WRITE;
  logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS;
  logic [BLK_W-1:0]        MEM_WRITEDATA;
  logic [BLK_W-1:0]        MEM_READDATA;
  logic                    MEM_BUSYWAIT;
  logic [CNT_W-1:0]        HIT_COUNT;
  logic [CNT_W-1:0]        MISS_COUNT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
           HIT_COUNT, MISS_COUNT
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
           HIT_COUNT, MISS_COUNT
  );

endinterface

// File: rtl/dcache_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Ports: CLK, RESET (async, active-high), inc, count.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports: CLK, RESET (async, active-high), bus (dcache_ctrl_if.slave) carrying the
// CPU READ/WRITE/BUSYWAIT port, the block memory port and the hit/miss counters.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned NUM_SETS        = 8,
  parameter int unsigned CNT_W           = 16
) (
  input logic          CLK,
  input logic          RESET,
  dcache_ctrl_if.slave bus
);

  localparam int unsigned OFF_W = off_w(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W = idx_w(NUM_SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, WORDS_PER_BLOCK, NUM_SETS);
  localparam int unsigned BLK_W = DATA_W * WORDS_PER_BLOCK;

  logic [1:0]              state;
  logic [1:0]              next_state;
  logic [NUM_SETS-1:0]     valid;
  logic [NUM_SETS-1:0]     dirty;
  logic                    missed;
  logic [TAG_W-1:0]        tag_arr  [NUM_SETS];
  logic [BLK_W-1:0]        data_arr [NUM_SETS];

  logic [OFF_W-1:0]        req_off;
  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    req;
  logic                    hit;
  logic                    complete;
  logic                    load_addr;

  logic                    mem_read_d;
  logic                    mem_write_d;
  logic [ADDR_W-OFF_W-1:0] mem_addr_d;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [ADDR_W-OFF_W-1:0] mem_addr_q;
  logic [BLK_W-1:0]        mem_wdata_q;

  // Address split and combinational hit lookup.
  assign req_off  = bus.ADDRESS[OFF_W-1:0];
  assign req_idx  = bus.ADDRESS[OFF_W +: IDX_W];
  assign req_tag  = bus.ADDRESS[ADDR_W-1 -: TAG_W];
  assign req      = bus.READ | bus.WRITE;
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign complete = req && (state == IDLE) && hit;

  // Zero-stall CPU side: stall and load data are combinational by design.
  assign bus.BUSYWAIT      = req && !((state == IDLE) && hit);
  assign bus.READDATA      = data_arr[req_idx][req_off*DATA_W +: DATA_W];
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;

  // Next-state and memory-request decode.
  always_comb begin
    next_state  = state;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = {req_tag, req_idx};
    case (state)
      IDLE:      if (req && !hit)
                   next_state = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : FETCH;
      WRITEBACK: if (!bus.MEM_BUSYWAIT) next_state = FETCH;
      FETCH:     if (!bus.MEM_BUSYWAIT) next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    mem_write_d = (next_state == WRITEBACK);
    mem_read_d  = (next_state == FETCH);
    if (next_state == WRITEBACK) mem_addr_d = {tag_arr[req_idx], req_idx};
  end

  // Memory address/data only load on entry to a memory phase so they stay put while busy.
  assign load_addr = (next_state != state) &&
                     ((next_state == WRITEBACK) || (next_state == FETCH));

  // State, line status and memory request registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      missed      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= next_state;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      if (load_addr) mem_addr_q <= mem_addr_d;
      if (next_state == WRITEBACK && state == IDLE) mem_wdata_q <= data_arr[req_idx];
      if (state == UPDATE) begin
        valid[req_idx] <= 1'b1;
        dirty[req_idx] <= 1'b0;
      end else if (complete && bus.WRITE) begin
        dirty[req_idx] <= 1'b1;
      end
      if (state == IDLE && next_state != IDLE) missed <= 1'b1;
      else if (complete)                       missed <= 1'b0;
    end
  end

  // Tag and data storage; not cleared by reset.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data_arr[req_idx] <= bus.MEM_READDATA;
      tag_arr[req_idx]  <= req_tag;
    end else if (complete && bus.WRITE) begin
      data_arr[req_idx][req_off*DATA_W +: DATA_W] <= bus.WRITEDATA;
    end
  end

  // A miss counts once when it leaves IDLE; a hit counts only for accesses that never missed.
  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (complete && !missed),
    .count (bus.HIT_COUNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   ((state == IDLE) && req && !hit),
    .count (bus.MISS_COUNT)
  );

endmodule
